// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch / countdown timer family:
// count width, largest displayable count, FSM state encoding and preset saturation.
package stopwatch_pkg;

  localparam int COUNT_W = 14;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Clamp a raw 14-bit value into the 0..COUNT_MAX display range.
  function automatic logic [COUNT_W-1:0] sat_count(input logic [COUNT_W-1:0] v);
    return (v > COUNT_MAX) ? COUNT_MAX : v;
  endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Prescaler for the countdown timer: emits a one-cycle tick every DIV enabled clocks.
// The count holds while en is low, so a paused run resumes mid-period.
module timer_tick_gen #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (cnt_reg == LAST) cnt_reg <= '0;
      else                 cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting 0..9999 timer with run/pause/expire control and registered outputs.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset at zero instead of stopping in EXPIRED.
module countdown_timer
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               expired,
  output logic               done
);

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [COUNT_W-1:0] preset_reg, preset_next;
  logic               running_reg, expired_reg, done_reg;
  logic               done_next;
  logic               presc_clr;
  logic               tick;
  logic [COUNT_W-1:0] load_sat;

  assign load_sat = sat_count(load_val);

  timer_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_reg == RUN),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      preset_reg  <= '0;
      running_reg <= 1'b0;
      expired_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      preset_reg  <= preset_next;
      running_reg <= (state_next == RUN);
      expired_reg <= (state_next == EXPIRED);
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    preset_next = preset_reg;
    done_next   = 1'b0;
    presc_clr   = 1'b0;

    if (clear) begin
      count_next = preset_reg;
      state_next = IDLE;
      presc_clr  = 1'b1;
    end else if (load && (state_reg != RUN)) begin
      preset_next = load_sat;
      count_next  = load_sat;
      state_next  = IDLE;
      presc_clr   = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_stop && (count_reg != '0)) state_next = RUN;
        end
        RUN: begin
          if (tick) begin
            if (count_reg > COUNT_W'(1)) begin
              count_next = count_reg - COUNT_W'(1);
            end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_next = preset_reg;
              done_next  = 1'b1;
`else
              count_next = '0;
              done_next  = 1'b1;
              state_next = EXPIRED;
              presc_clr  = 1'b1;
`endif
            end
          end
          // A pause on the expiring edge loses to EXPIRED.
          if (start_stop && (state_next == RUN)) state_next = PAUSE;
        end
        PAUSE: begin
          if (start_stop) state_next = RUN;
        end
        default: begin
        end
      endcase
    end
  end

  assign count   = count_reg;
  assign running = running_reg;
  assign expired = expired_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with DIV=4; expectations queue up per driven cycle.
// Build with COUNTDOWN_AUTO_RELOAD_EN defined to exercise the auto-reload variant.
module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic        load;
  logic [13:0] load_val;
  logic [13:0] count;
  logic        running;
  logic        expired;
  logic        done;

  typedef struct {
    logic [13:0] cnt;
    logic        run;
    logic        expd;
    logic        dn;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  countdown_timer #(.DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic [13:0] ec, input logic er,
                          input logic ee, input logic ed);
    exp_t e;
    e.cnt  = ec;
    e.run  = er;
    e.expd = ee;
    e.dn   = ed;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    $display("%0t %s: count=%0d running=%0b expired=%0b done=%0b",
             $time, t, count, running, expired, done);
    check({t, ".count"},   32'(count),   32'(e.cnt));
    check({t, ".running"}, 32'(running), 32'(e.run));
    check({t, ".expired"}, 32'(expired), 32'(e.expd));
    check({t, ".done"},    32'(done),    32'(e.dn));
  endtask

  // Drive one cycle of stimulus, then compare the outputs registered at that edge.
  task automatic cyc(input logic ss, input logic clr, input logic ld, input logic [13:0] lv,
                     input string tag, input logic [13:0] ec, input logic er,
                     input logic ee, input logic ed);
    start_stop = ss;
    clear      = clr;
    load       = ld;
    load_val   = lv;
    push_exp(tag, ec, er, ee, ed);
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    pop_check();
  endtask

  task automatic idle(input int n, input string tag, input logic [13:0] ec,
                      input logic er, input logic ee);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 14'd0, tag, ec, er, ee, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    #12;
    push_exp("reset", 14'd0, 1'b0, 1'b0, 1'b0);
    pop_check();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Preset saturation and start with zero count
    cyc(0, 0, 1, 14'd12000, "load_12000", 14'd9999, 0, 0, 0);
    cyc(0, 0, 1, 14'd10000, "load_10000", 14'd9999, 0, 0, 0);
    cyc(0, 0, 1, 14'd9999,  "load_9999",  14'd9999, 0, 0, 0);
    cyc(0, 0, 1, 14'd0,     "load_0",     14'd0,    0, 0, 0);
    cyc(1, 0, 0, 14'd0,     "start_at_0", 14'd0,    0, 0, 0);
    idle(6, "idle_at_0", 14'd0, 0, 0);

    // Pause two clocks after the first decrement, resume completes the partial period
    cyc(0, 0, 1, 14'd5, "load_5",    14'd5, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "start_5",   14'd5, 1, 0, 0);
    idle(3, "run_5", 14'd5, 1, 0);
    cyc(0, 0, 0, 14'd0, "dec_4",     14'd4, 1, 0, 0);
    idle(1, "run_4", 14'd4, 1, 0);
    cyc(1, 0, 0, 14'd0, "pause_4",   14'd4, 0, 0, 0);
    idle(20, "paused_4", 14'd4, 0, 0);
    cyc(1, 0, 0, 14'd0, "resume_4",  14'd4, 1, 0, 0);
    idle(1, "resumed_4", 14'd4, 1, 0);
    cyc(0, 0, 0, 14'd0, "dec_3",     14'd3, 1, 0, 0);

    // Load ignored in RUN; clear beats load and start_stop
    cyc(0, 0, 1, 14'd7, "load_in_run", 14'd3, 1, 0, 0);
    cyc(1, 1, 1, 14'd7, "clr_ld_ss",   14'd5, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "restart_5",   14'd5, 1, 0, 0);
    cyc(0, 1, 0, 14'd0, "clear_run",   14'd5, 0, 0, 0);

    // Tick and start_stop on the same edge at count 2
    cyc(0, 0, 1, 14'd2, "load_2",      14'd2, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "start_2",     14'd2, 1, 0, 0);
    idle(3, "run_2", 14'd2, 1, 0);
    cyc(1, 0, 0, 14'd0, "tick_ss_2",   14'd1, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "resume_1",    14'd1, 1, 0, 0);
    idle(3, "run_1", 14'd1, 1, 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    cyc(1, 0, 0, 14'd0, "tick_ss_1",   14'd0, 0, 1, 1);
    cyc(0, 0, 0, 14'd0, "expired_hold", 14'd0, 0, 1, 0);
    cyc(1, 0, 0, 14'd0, "ss_in_expired", 14'd0, 0, 1, 0);

    // Full countdown 3 -> 0 at 4-clock spacing
    cyc(0, 0, 1, 14'd3, "load_3",      14'd3, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "start_3",     14'd3, 1, 0, 0);
    idle(3, "run_3", 14'd3, 1, 0);
    cyc(0, 0, 0, 14'd0, "dec_2",       14'd2, 1, 0, 0);
    idle(3, "run_2b", 14'd2, 1, 0);
    cyc(0, 0, 0, 14'd0, "dec_1",       14'd1, 1, 0, 0);
    idle(3, "run_1b", 14'd1, 1, 0);
    cyc(0, 0, 0, 14'd0, "expire",      14'd0, 0, 1, 1);
    cyc(0, 0, 0, 14'd0, "done_drop",   14'd0, 0, 1, 0);
    cyc(0, 0, 0, 14'd0, "expired_lvl", 14'd0, 0, 1, 0);
    cyc(0, 1, 0, 14'd0, "clear_exp",   14'd3, 0, 0, 0);
`else
    cyc(1, 0, 0, 14'd0, "tick_ss_1",   14'd2, 0, 0, 1);
    cyc(0, 0, 0, 14'd0, "paused_2",    14'd2, 0, 0, 0);

    // Auto-reload sequence 2,1,2,1,2 with done at each reload
    cyc(0, 0, 1, 14'd2, "load_2r",     14'd2, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "start_2r",    14'd2, 1, 0, 0);
    idle(3, "run_2r", 14'd2, 1, 0);
    cyc(0, 0, 0, 14'd0, "dec_1r",      14'd1, 1, 0, 0);
    idle(3, "run_1r", 14'd1, 1, 0);
    cyc(0, 0, 0, 14'd0, "reload_a",    14'd2, 1, 0, 1);
    idle(3, "run_2r2", 14'd2, 1, 0);
    cyc(0, 0, 0, 14'd0, "dec_1r2",     14'd1, 1, 0, 0);
    idle(3, "run_1r2", 14'd1, 1, 0);
    cyc(0, 0, 0, 14'd0, "reload_b",    14'd2, 1, 0, 1);
    cyc(0, 1, 0, 14'd0, "clear_auto",  14'd2, 0, 0, 0);
`endif

    // Asynchronous reset mid-run, between clock edges
    cyc(0, 0, 1, 14'd9, "load_9",      14'd9, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "start_9",     14'd9, 1, 0, 0);
    idle(2, "run_9", 14'd9, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    push_exp("async_reset", 14'd0, 0, 0, 0);
    pop_check();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 1, 0, 14'd0, "preset_lost", 14'd0, 0, 0, 0);
    cyc(1, 0, 0, 14'd0, "start_after_rst", 14'd0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
